// File: rtl/regfile_param_if.sv
// Bundle of register-file access signals shared between decode/writeback
// (master) and the register file (slave).
interface regfile_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    logic              ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              sb_set;
    logic [ADDR_W-1:0] sb_addr;
    logic              busy1;
    logic              busy2;

    modport master (
        output we, waddr, wdata, ra1, ra2, sb_set, sb_addr,
        input  ready, rd1, rd2, busy1, busy2
    );

    modport slave (
        input  we, waddr, wdata, ra1, ra2, sb_set, sb_addr,
        output ready, rd1, rd2, busy1, busy2
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: clear sequencer after reset, write-first read
// bypass on two combinational read ports, and a per-entry busy scoreboard.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    regfile_param_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_waddr_s;
    logic [DATA_W-1:0]   mem_wdata_s;
    logic                run_s;
    logic [DATA_W-1:0]   rd1_s, rd2_s;
    logic                busy1_s, busy2_s;

    // Entry 0 is hardwired to zero only when ZERO_REG is enabled.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == {ADDR_W{1'b0}});
    endfunction

    // Read data for one port: zero register, then same-cycle bypass, then array.
    function automatic logic [DATA_W-1:0] read_sel(
        input logic              run,
        input logic [ADDR_W-1:0] ra,
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd,
        input logic [DATA_W-1:0] mv
    );
        logic [DATA_W-1:0] r;
        r = {DATA_W{1'b0}};
        if (!run) begin
            r = {DATA_W{1'b0}};
        end else if (is_zero_reg(ra)) begin
            r = {DATA_W{1'b0}};
        end else if (we && (wa == ra)) begin
            r = wd;
        end else begin
            r = mv;
        end
        return r;
    endfunction

    // Busy for one port: hidden while the producing write is being bypassed.
    function automatic logic busy_sel(
        input logic              run,
        input logic [ADDR_W-1:0] ra,
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic              bv
    );
        logic b;
        b = 1'b0;
        if (!run) begin
            b = 1'b0;
        end else if (is_zero_reg(ra)) begin
            b = 1'b0;
        end else if (we && (wa == ra)) begin
            b = 1'b0;
        end else begin
            b = bv;
        end
        return b;
    endfunction

    assign run_s = (state_q == ST_RUN);

    // Next-state logic: clear sequencing in INIT, writes and scoreboard in RUN.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = idx_q;
        mem_wdata_s = {DATA_W{1'b0}};
        case (state_q)
            ST_INIT: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = idx_q;
                mem_wdata_s = {DATA_W{1'b0}};
                idx_d       = idx_q + ADDR_W'(1);
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                mem_we_s    = bus.we && !is_zero_reg(bus.waddr);
                mem_waddr_s = bus.waddr;
                mem_wdata_s = bus.wdata;
                if (bus.we) begin
                    busy_d[bus.waddr] = 1'b0;
                end else begin
                    busy_d = busy_d;
                end
                // A new producer issued this cycle supersedes the retiring one.
                if (bus.sb_set && !is_zero_reg(bus.sb_addr)) begin
                    busy_d[bus.sb_addr] = 1'b1;
                end else begin
                    busy_d = busy_d;
                end
            end
            default: begin
                state_d = ST_INIT;
                idx_d   = {ADDR_W{1'b0}};
                busy_d  = {DEPTH{1'b0}};
            end
        endcase
    end

    // Control state: FSM, clear index and scoreboard, async cleared on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            idx_q   <= {ADDR_W{1'b0}};
            busy_q  <= {DEPTH{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    // Storage array: contents are made deterministic by the clear sequence.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Combinational read ports and busy status.
    always_comb begin
        rd1_s   = read_sel(run_s, bus.ra1, bus.we, bus.waddr, bus.wdata, mem_q[bus.ra1]);
        rd2_s   = read_sel(run_s, bus.ra2, bus.we, bus.waddr, bus.wdata, mem_q[bus.ra2]);
        busy1_s = busy_sel(run_s, bus.ra1, bus.we, bus.waddr, busy_q[bus.ra1]);
        busy2_s = busy_sel(run_s, bus.ra2, bus.we, bus.waddr, busy_q[bus.ra2]);
    end

    assign bus.ready = run_s;
    assign bus.rd1   = rd1_s;
    assign bus.rd2   = rd2_s;
    assign bus.busy1 = busy1_s;
    assign bus.busy2 = busy2_s;
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two instances (ZERO_REG=1 and ZERO_REG=0) share
// stimulus; a behavioural model is compared on every falling edge, plus
// directed literal checks for reset, clear latency, bypass, zero register,
// scoreboard, collision and mid-operation reset.
module tb_regfile_param;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
    regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

    assign if1.we      = if0.we;
    assign if1.waddr   = if0.waddr;
    assign if1.wdata   = if0.wdata;
    assign if1.ra1     = if0.ra1;
    assign if1.ra2     = if0.ra2;
    assign if1.sb_set  = if0.sb_set;
    assign if1.sb_addr = if0.sb_addr;

    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut0 (
        .clk(clk), .rst(rst), .bus(if0)
    );
    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [DW-1:0] mem_m  [2][DEPTH];
    logic          busy_m [2][DEPTH];
    logic          rdy_m  [2] = '{1'b0, 1'b0};
    int            cnt_m  [2] = '{0, 0};

    function automatic logic zr(input int k);
        return (k == 0);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                rdy_m[k] <= 1'b0;
                cnt_m[k] <= 0;
                for (int i = 0; i < DEPTH; i++) busy_m[k][i] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!rdy_m[k]) begin
                    cnt_m[k] <= cnt_m[k] + 1;
                    if (cnt_m[k] == DEPTH - 1) begin
                        rdy_m[k] <= 1'b1;
                        for (int i = 0; i < DEPTH; i++) mem_m[k][i] <= 32'd0;
                    end
                end else begin
                    if (if0.we && !(zr(k) && if0.waddr == 5'd0))
                        mem_m[k][if0.waddr] <= if0.wdata;
                    if (if0.we)
                        busy_m[k][if0.waddr] <= 1'b0;
                    if (if0.sb_set && !(zr(k) && if0.sb_addr == 5'd0))
                        busy_m[k][if0.sb_addr] <= 1'b1;
                end
            end
        end
    end

    function automatic logic [DW-1:0] exp_rd(input int k, input logic [AW-1:0] ra);
        if (!rdy_m[k]) return 32'd0;
        if (zr(k) && ra == 5'd0) return 32'd0;
        if (if0.we && if0.waddr == ra) return if0.wdata;
        return mem_m[k][ra];
    endfunction

    function automatic logic exp_busy(input int k, input logic [AW-1:0] ra);
        if (!rdy_m[k]) return 1'b0;
        if (zr(k) && ra == 5'd0) return 1'b0;
        if (if0.we && if0.waddr == ra) return 1'b0;
        return busy_m[k][ra];
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("m0_ready", {31'd0, if0.ready}, {31'd0, rdy_m[0]});
        chk("m0_rd1",   if0.rd1, exp_rd(0, if0.ra1));
        chk("m0_rd2",   if0.rd2, exp_rd(0, if0.ra2));
        chk("m0_busy1", {31'd0, if0.busy1}, {31'd0, exp_busy(0, if0.ra1)});
        chk("m0_busy2", {31'd0, if0.busy2}, {31'd0, exp_busy(0, if0.ra2)});
        chk("m1_ready", {31'd0, if1.ready}, {31'd0, rdy_m[1]});
        chk("m1_rd1",   if1.rd1, exp_rd(1, if1.ra1));
        chk("m1_rd2",   if1.rd2, exp_rd(1, if1.ra2));
        chk("m1_busy1", {31'd0, if1.busy1}, {31'd0, exp_busy(1, if1.ra1)});
        chk("m1_busy2", {31'd0, if1.busy2}, {31'd0, exp_busy(1, if1.ra2)});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if0.we = 1'b0; if0.sb_set = 1'b0;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    // ---------------- directed + random stimulus ----------------
    initial begin
        if0.we = 1'b0; if0.waddr = 5'd0; if0.wdata = 32'd0;
        if0.ra1 = 5'd0; if0.ra2 = 5'd0; if0.sb_set = 1'b0; if0.sb_addr = 5'd0;
        #1 rst = 1'b0;
        repeat (3) step();
        chk("rst_ready", {31'd0, if0.ready}, 32'd0);
        chk("rst_rd1",   if0.rd1, 32'd0);
        chk("rst_busy1", {31'd0, if0.busy1}, 32'd0);

        // Release and count clear edges; INIT write/sb_set to x5 must be ignored.
        #1 rst = 1'b1;
        if0.we = 1'b1; if0.waddr = 5'd5; if0.wdata = 32'h0000DEAD;
        if0.sb_set = 1'b1; if0.sb_addr = 5'd5;
        for (int e = 1; e <= DEPTH; e++) begin
            step();
            if (e == DEPTH - 1) chk("clr_ready31", {31'd0, if0.ready}, 32'd0);
            if (e == DEPTH)     chk("clr_ready32", {31'd0, if0.ready}, 32'd1);
        end
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            if0.ra1 = AW'(i); if0.ra2 = AW'(DEPTH - 1 - i);
            #1;
            chk("clr_rd1_z",   if1.rd1, 32'd0);
            chk("clr_rd2_z",   if1.rd2, 32'd0);
            chk("clr_busy1_z", {31'd0, if1.busy1}, 32'd0);
        end
        if0.ra1 = 5'd5; #1;
        chk("init_x5", if0.rd1, 32'd0);

        // Write/read with bypass.
        step();
        if0.ra1 = 5'd7; if0.we = 1'b1; if0.waddr = 5'd7; if0.wdata = 32'h12345678;
        #1 chk("byp_rd1", if0.rd1, 32'h12345678);
        step(); idle();
        #1 chk("post_rd1", if0.rd1, 32'h12345678);
        chk("model_x7", mem_m[0][7], 32'h12345678);

        // Zero register (inst0) vs plain x0 (inst1).
        step();
        if0.ra1 = 5'd0; if0.we = 1'b1; if0.waddr = 5'd0; if0.wdata = 32'hFFFFFFFF;
        if0.sb_set = 1'b1; if0.sb_addr = 5'd0;
        #1;
        chk("z_rd1_wc",   if0.rd1, 32'd0);
        chk("z_busy1_wc", {31'd0, if0.busy1}, 32'd0);
        chk("nz_rd1_wc",  if1.rd1, 32'hFFFFFFFF);
        step(); idle();
        #1;
        chk("z_rd1",    if0.rd1, 32'd0);
        chk("z_busy1",  {31'd0, if0.busy1}, 32'd0);
        chk("nz_rd1",   if1.rd1, 32'hFFFFFFFF);
        chk("nz_busy1", {31'd0, if1.busy1}, 32'd1);

        // Scoreboard on x3.
        step();
        if0.ra1 = 5'd3; if0.sb_set = 1'b1; if0.sb_addr = 5'd3;
        step(); idle();
        #1 chk("sb_busy_c1", {31'd0, if0.busy1}, 32'd1);
        step();
        chk("sb_busy_c2", {31'd0, if0.busy1}, 32'd1);
        if0.we = 1'b1; if0.waddr = 5'd3; if0.wdata = 32'h000000A5;
        #1;
        chk("sb_busy_wc", {31'd0, if0.busy1}, 32'd0);
        chk("sb_rd_wc",   if0.rd1, 32'h000000A5);
        step(); idle();
        #1;
        chk("sb_busy_after", {31'd0, if0.busy1}, 32'd0);
        chk("sb_rd_after",   if0.rd1, 32'h000000A5);

        // Set/clear collision on x9: set wins.
        step();
        if0.ra1 = 5'd9; if0.ra2 = 5'd9;
        if0.sb_set = 1'b1; if0.sb_addr = 5'd9;
        if0.we = 1'b1; if0.waddr = 5'd9; if0.wdata = 32'h00000055;
        #1 chk("col_busy_wc", {31'd0, if0.busy1}, 32'd0);
        step(); idle();
        #1;
        chk("col_busy1", {31'd0, if0.busy1}, 32'd1);
        chk("col_busy2", {31'd0, if0.busy2}, 32'd1);
        chk("col_rd1",   if0.rd1, 32'h00000055);
        chk("col_rd2",   if0.rd2, 32'h00000055);
        chk("model_busy9", {31'd0, busy_m[0][9]}, 32'd1);

        // Reset mid-operation.
        step();
        if0.we = 1'b1; if0.waddr = 5'd4; if0.wdata = 32'h00000077;
        step(); idle();
        if0.ra1 = 5'd4; if0.ra2 = 5'd4;
        #1 chk("mr_pre", if0.rd1, 32'h00000077);
        rst = 1'b0;
        #1;
        chk("mr_ready", {31'd0, if0.ready}, 32'd0);
        chk("mr_rd1",   if0.rd1, 32'd0);
        chk("mr_rd2",   if1.rd2, 32'd0);
        #1 rst = 1'b1;
        for (int e = 1; e <= DEPTH; e++) step();
        chk("mr_ready_back", {31'd0, if0.ready}, 32'd1);
        chk("mr_x4", if0.rd1, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            if0.ra1 = AW'(i); #1;
            chk("mr_busy0", {31'd0, if1.busy1}, 32'd0);
        end

        // Randomized traffic, with one reset in the middle.
        step();
        for (int c = 0; c < 600; c++) begin
            if0.we      = ($urandom_range(0, 1) == 1);
            if0.waddr   = rnd_addr();
            if0.wdata   = $urandom;
            if0.ra1     = rnd_addr();
            if0.ra2     = ($urandom_range(0, 4) == 0) ? if0.ra1 : rnd_addr();
            if0.sb_set  = ($urandom_range(0, 2) == 0);
            if0.sb_addr = rnd_addr();
            if (c == 300) begin
                #1 rst = 1'b0;
                #1 rst = 1'b1;
            end
            step();
        end
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-port register file with a hardware clear sequencer, write-first read bypass and a per-register busy scoreboard. Sits in the decode stage of the RISC-V core: two combinational read ports feed the operand path, one write port is driven from writeback, and the scoreboard lets decode stall on registers with an outstanding producer. On reset, every entry is cleared to zero by an internal sequencer. Architectural state is then deterministic without an initial block.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, when 1, entry 0 reads 0 and ignores writes and busy sets
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ready  out  1  high once the clear sequence has finished
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- ra1, ra2  in  ADDR_W  read addresses
- rd1, rd2  out  DATA_W  read data (combinational)
- sb_set  in  1  mark sb_addr busy (producer issued)
- sb_addr  in  ADDR_W  scoreboard set address
- busy1, busy2  out  1  busy status of ra1 / ra2 (combinational)

## Operation
- States: INIT and RUN. Entering reset (rst=0) forces INIT asynchronously.
- In INIT:
  - Clear index idx resets to 0 and ready=0.
  - The busy vector resets to all 0.
- INIT, each rising edge with rst=1:
  - mem[idx] <= 0, idx <= idx+1.
  - After writing idx=DEPTH-1, move to RUN and set ready=1.
- During INIT:
  - we and sb_set are ignored.
  - rd1/rd2 = 0 and busy1/busy2 = 0.
- RUN write: on a rising edge with we=1, mem[waddr] <= wdata. If ZERO_REG=1 and waddr=0, the write is dropped.
- RUN read: rdN = mem[raN], with the following overrides:
  - If ZERO_REG=1 and raN=0, rdN = 0.
  - Else if we=1 and waddr=raN, rdN = wdata (write-first bypass).
- Scoreboard: busy is a DEPTH-bit register. On each RUN rising edge:
  - sb_set=1 sets busy[sb_addr].
  - we=1 clears busy[waddr].
  - If both target the same address in the same cycle, set wins (new producer supersedes the retiring one).
  - With ZERO_REG=1, address 0 is never busy.
- busyN:
  - busyN = busy[raN], except busyN = 0 when we=1 and waddr=raN (the value is being bypassed this cycle).
  - A same-cycle sb_set does not affect busyN until the next cycle.
- Reset mid-operation (rst low at any time): return to INIT.
  - Any in-flight write on that edge is lost.
  - The full clear sequence reruns after release.
- Two read ports may address the same entry. Both return identical data and busy.

## Timing
- Reset values: ready=0, rd1=rd2=0, busy1=busy2=0, idx=0, busy vector=0.
- Clear latency: ready rises after exactly DEPTH rising edges with rst=1 (32 for defaults). It is visible directly after the DEPTH-th edge.
- Write-to-read: a write on edge N is visible through mem from edge N onward. The same-cycle value is visible before edge N via the bypass.
- sb_set on edge N → busyN=1 from edge N until the clearing write's cycle. The bypass makes busy low during that write cycle itself.
- Read paths and busy outputs are purely combinational from ra*/we/waddr/wdata and state. There is no read latency.
- rst assertion affects ready, rd*, and busy* immediately, without a clock edge.

## Test plan
- Reset and clear:
  - Stimulus: hold rst=0, release, then count edges.
  - Required: ready=0 for 31 edges and 1 after the 32nd. All 32 reads return 0. A write of 0xDEAD to x5 during INIT is not stored (reading x5 in RUN gives 0).
- Write/read with bypass:
  - Stimulus: write x7=0x12345678; in the same cycle set ra1=7.
  - Required: rd1=0x12345678 before the edge. After the edge, with we=0, rd1 is still 0x12345678.
- Zero register:
  - Stimulus: ZERO_REG=1, write x0=0xFFFFFFFF, sb_set x0.
  - Required: rd1(ra1=0)=0, busy1=0, including in the write cycle. Rerun with ZERO_REG=0: x0 reads 0xFFFFFFFF.
- Scoreboard:
  - Stimulus: sb_set x3, wait 2 cycles, then write x3=0xA5.
  - Required: busy1=1 for the two cycles, busy1=0 during the write cycle and afterwards, and rd1=0xA5.
- Set/clear collision:
  - Stimulus: in one cycle, assert sb_set x9 and we to x9 with 0x55.
  - Required: the next cycle shows busy for x9 = 1 and rd=0x55.
- Reset mid-operation:
  - Stimulus: write x4=0x77, then pulse rst=0 mid-cycle.
  - Required: ready and rd* drop to 0 immediately. After release and 32 edges, x4 reads 0 and all busy bits read 0.
